regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- 32-entry general-purpose register file with a per-register pending-write scoreboard.
- Sits directly downstream of the 5-bit destination-register select mux, which picks between the rt and rd fields. The mux output drives issue_addr at decode and wb_addr at write-back.
- Provides two combinational read ports, one synchronous write port, and a stall indication when a source register has a write still in flight.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W (32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- issue_en  input  1  an instruction with a destination register is issued this cycle.
- issue_addr  input  ADDR_W  destination register of the issuing instruction (from the dest mux).
- wb_en  input  1  write-back valid this cycle.
- wb_addr  input  ADDR_W  write-back destination (from the pipelined dest mux output).
- wb_data  input  DATA_W  write-back data.
- stall  output  1  a source register of the current instruction is pending.
- pending  output  2**ADDR_W  scoreboard bit vector; bit i set means a write to register i is outstanding.

Behaviour:
- Storage: regs[0..31] of DATA_W bits; pend[0..31] of 1 bit each.
- Register 0:
  - Reads always return 0.
  - Writes to it are discarded.
  - pend[0] is never set.
- Reset (reset=1 at a clock edge):
  - All regs cleared to 0 and all pend bits cleared.
  - Overrides any same-cycle issue_en or wb_en.
  - Reset asserted mid-operation drops all in-flight pending state.
- Reset values of outputs after reset:
  - rs_data = rt_data = 0.
  - pending = 0.
  - stall = 0.
- Reads:
  - Combinational, zero latency: rs_data = regs[rs_addr], rt_data = regs[rt_addr].
  - Without the bypass feature, a same-cycle write is not visible until the next cycle.
- Write:
  - On the clock edge with wb_en=1 and wb_addr!=0: regs[wb_addr] <= wb_data.
  - The same write clears pend[wb_addr].
- Issue:
  - On the clock edge with issue_en=1 and issue_addr!=0, pend[issue_addr] is set.
- Simultaneous issue and write-back to the same address:
  - pend stays set: the newer issue wins.
  - The register data is still updated with wb_data.
- Write-back to a register that is not pending: data is written, pend stays 0, no error.
- Stall:
  - Combinational: stall = (rs_addr!=0 and pend[rs_addr]) or (rt_addr!=0 and pend[rt_addr]).
  - stall does not gate issue_en internally; upstream control must suppress issue while stall=1.
- Addressing: all addresses are full ADDR_W decode with no wrap or aliasing. Address 31 is valid.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Write-through forwarding: if wb_en=1, wb_addr!=0 and wb_addr equals a read address, that read port returns wb_data in the same cycle.
  - stall also ignores a pend bit that is being cleared by the same-cycle write-back, unless a same-cycle issue re-sets it.
  - Read of register 0 still returns 0.
- Not defined:
  - Reads return stored contents only.
  - stall is computed from the registered pend bits alone.

Test Plan:
- Reset then read: assert reset 1 cycle; rs_addr=5, rt_addr=31 -> rs_data=0, rt_data=0, pending=0, stall=0.
- Write/read: wb_en=1, wb_addr=7, wb_data=0xDEADBEEF for one edge; then rs_addr=7 -> rs_data=0xDEADBEEF. Same cycle as the write with bypass off -> old value 0; with bypass on -> 0xDEADBEEF.
- Register 0: wb_en=1, wb_addr=0, wb_data=0xFFFFFFFF; issue_en=1, issue_addr=0 -> rs_addr=0 reads 0, pending[0]=0, stall=0.
- Scoreboard hazard:
  - Edge 1: issue_en=1, issue_addr=9.
  - Next cycle rt_addr=9 -> stall=1, pending=0x00000200.
  - Edge 2: wb_en=1, wb_addr=9, wb_data=0x12345678.
  - After edge 2 -> stall=0, rt_data=0x12345678.
  - With bypass on, stall=0 already in the write-back cycle.
- Simultaneous events:
  - Register 3 pending; same edge issue_en=1, issue_addr=3 and wb_en=1, wb_addr=3, wb_data=0xA5 -> pend[3]=1, regs[3]=0xA5.
  - Then reset asserted with issue_en=1, issue_addr=4 -> pending=0 and regs[3]=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// 32-entry register file with per-register pending-write scoreboard and stall detection.
// Optional write-through forwarding when REGFILE_WB_BYPASS_EN is defined.
module regfile_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    rs_addr,
  input  logic [ADDR_W-1:0]    rt_addr,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  input  logic                 issue_en,
  input  logic [ADDR_W-1:0]    issue_addr,
  input  logic                 wb_en,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 stall,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int unsigned Depth = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  pend_q, pend_d;
  logic [Depth-1:0]  wb_mask, issue_mask, pend_view;
  logic              wb_hit;

  assign wb_hit = wb_en && (wb_addr != '0);

  always_comb begin
    wb_mask    = '0;
    issue_mask = '0;
    if (wb_hit) wb_mask[wb_addr] = 1'b1;
    if (issue_en && (issue_addr != '0)) issue_mask[issue_addr] = 1'b1;
    // A same-edge issue sets the bit after the write-back clears it: newer issue wins.
    pend_d = (pend_q & ~wb_mask) | issue_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      if (wb_hit) regs_q[wb_addr] <= wb_data;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) rs_data = regs_q[rs_addr];
    if (rt_addr != '0) rt_data = regs_q[rt_addr];
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_hit && (wb_addr == rs_addr)) rs_data = wb_data;
    if (wb_hit && (wb_addr == rt_addr)) rt_data = wb_data;
    // A bit being retired this edge no longer blocks, unless it is re-issued too.
    pend_view = pend_q & ~(wb_mask & ~issue_mask);
`else
    pend_view = pend_q;
`endif
    stall = ((rs_addr != '0) && pend_view[rs_addr]) || ((rt_addr != '0) && pend_view[rt_addr]);
  end

  assign pending = pend_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vectors plus an array-based reference
// model compared every cycle on the falling clock edge.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, issue_addr, wb_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        issue_en, wb_en, stall;
  logic [31:0] pending;

  int checks = 0;
  int failures = 0;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .stall      (stall),
    .pending    (pending)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  // Reference model: plain arrays updated by the architectural rules.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (Bypass && wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit busy(input logic [4:0] a);
    if (a == 0 || !m_pend[a]) return 1'b0;
    if (Bypass && wb_en && wb_addr == a && !(issue_en && issue_addr == a)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= 32'h0;
        m_pend[i] <= 1'b0;
      end
      model_ok <= 1'b1;
    end else begin
      if (wb_en && wb_addr != 0) begin
        m_regs[wb_addr] <= wb_data;
        if (!(issue_en && issue_addr == wb_addr)) m_pend[wb_addr] <= 1'b0;
      end
      if (issue_en && issue_addr != 0) m_pend[issue_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_rs_data", rs_data, exp_read(rs_addr));
      chk("model_rt_data", rt_data, exp_read(rt_addr));
      chk("model_stall", {31'h0, stall}, {31'h0, busy(rs_addr) || busy(rt_addr)});
      chk("model_pending", pending, exp_pending());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 0; issue_addr = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  initial begin
    reset = 1; rs_addr = 0; rt_addr = 0;
    idle();
    tick(); tick();
    reset = 0; rs_addr = 5; rt_addr = 31;
    #1;
    chk("reset_rs_data", rs_data, 32'h0);
    chk("reset_rt_data", rt_data, 32'h0);
    chk("reset_pending", pending, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);

    // Write/read, including same-cycle visibility
    tick();
    wb_en = 1; wb_addr = 7; wb_data = 32'hDEADBEEF; rs_addr = 7;
    #1;
    chk("wb_same_cycle", rs_data, Bypass ? 32'hDEADBEEF : 32'h0);
    tick();
    idle();
    #1;
    chk("wb_read_back", rs_data, 32'hDEADBEEF);

    // Register 0 is hardwired
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF; issue_en = 1; issue_addr = 0; rs_addr = 0;
    tick();
    idle();
    #1;
    chk("r0_read", rs_data, 32'h0);
    chk("r0_pending", {31'h0, pending[0]}, 32'h0);
    chk("r0_stall", {31'h0, stall}, 32'h0);

    // Address 31 boundary
    wb_en = 1; wb_addr = 31; wb_data = 32'h0BADF00D;
    tick();
    idle();
    rt_addr = 31;
    #1;
    chk("r31_read", rt_data, 32'h0BADF00D);

    // Scoreboard hazard
    rs_addr = 0; rt_addr = 0;
    issue_en = 1; issue_addr = 9;
    tick();
    idle();
    rt_addr = 9;
    #1;
    chk("hazard_stall", {31'h0, stall}, 32'h1);
    chk("hazard_pending", pending, 32'h00000200);
    wb_en = 1; wb_addr = 9; wb_data = 32'h12345678;
    #1;
    chk("hazard_wb_cycle_stall", {31'h0, stall}, Bypass ? 32'h0 : 32'h1);
    tick();
    idle();
    #1;
    chk("hazard_clear_stall", {31'h0, stall}, 32'h0);
    chk("hazard_rt_data", rt_data, 32'h12345678);

    // Simultaneous issue and write-back, then reset overriding an issue
    issue_en = 1; issue_addr = 3;
    tick();
    wb_en = 1; wb_addr = 3; wb_data = 32'hA5;
    tick();
    idle();
    rs_addr = 3;
    #1;
    chk("simul_pending", pending, 32'h00000008);
    chk("simul_data", rs_data, 32'hA5);
    chk("simul_stall", {31'h0, stall}, 32'h1);
    reset = 1; issue_en = 1; issue_addr = 4;
    tick();
    reset = 0;
    idle();
    #1;
    chk("reset_mid_pending", pending, 32'h0);
    chk("reset_mid_data", rs_data, 32'h0);

    // Mixed traffic checked by the model every cycle
    for (int n = 0; n < 300; n++) begin
      rs_addr    = 5'($urandom_range(0, 31));
      rt_addr    = 5'($urandom_range(0, 31));
      issue_en   = ($urandom_range(0, 2) == 0);
      issue_addr = 5'($urandom_range(0, 31));
      wb_en      = ($urandom_range(0, 1) == 0);
      wb_addr    = ($urandom_range(0, 3) == 0) ? issue_addr : 5'($urandom_range(0, 31));
      wb_data    = $urandom;
      reset      = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 0;
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
